nf_input_debounce: RTL and testbench
====================================

NF_INPUT_DEBOUNCE -- requirements
Module: nf_input_debounce

Interface
REQ-001 Parameter WIDTH, default 12, number of independent input channels (sw[9:0] plus key[1:0] on the board).
REQ-002 Parameter DB_CYC, default 500000, number of consecutive stable clock cycles required to accept a new level (10 ms at 50 MHz); legal range 1..2^24.
REQ-003 Parameter RST_VAL, default '0, WIDTH-bit value loaded into dout at reset.
REQ-004 clk  input  1  system clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 din  input  WIDTH  raw asynchronous button/switch levels.
REQ-007 dout  output  WIDTH  debounced, clk-synchronous levels.
REQ-008 rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1 transition.
REQ-009 fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0 transition.

Function
REQ-010 Each din bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each channel SHALL hold a counter of width $clog2(DB_CYC+1), fully independent of the other channels.
REQ-012 When sync2 == dout for a bit, that bit's counter SHALL clear to 0 (glitch rejection; partial counts are discarded).
REQ-013 When sync2 != dout and counter < DB_CYC-1, counter SHALL increment by 1.
REQ-014 When sync2 != dout and counter == DB_CYC-1, on that edge dout SHALL take sync2 and counter SHALL clear to 0.
REQ-015 Counter SHALL never wrap; the terminal compare in REQ-014 bounds it.
REQ-016 Latency: a clean step on din SHALL appear on dout exactly DB_CYC+2 rising edges after the first edge that samples the new level.
REQ-017 rise/fall SHALL be registered, asserted in the same cycle dout changes, and deasserted the following cycle; rise and fall of one bit are never both high.
REQ-018 A pulse on din shorter than DB_CYC cycles (after sync) SHALL produce no change on dout, rise or fall.
REQ-019 A new transition opposite to a pending one SHALL restart counting from 0 (covered by REQ-012).
REQ-020 With DB_CYC=1, dout SHALL follow sync2 with one cycle delay (total latency 3).
REQ-021 Simultaneous transitions on several bits SHALL be debounced independently; equal-timed steps yield simultaneous pulses.

Reset
REQ-022 Assertion of reset SHALL immediately set dout=RST_VAL, rise=0, fall=0, all counters=0, sync1=sync2=RST_VAL.
REQ-023 Reset asserted mid-count SHALL discard the count; no pulse SHALL be generated by the reset itself or on its release.
REQ-024 After release, a din differing from RST_VAL SHALL be accepted per REQ-016 and generate the corresponding rise/fall pulse.

Structure
REQ-025 Package nf_db_pkg SHALL hold NF_CLK_FREQ (50_000_000), NF_DB_MS (10) and the derived default NF_DB_CYC.
REQ-026 One sub-module nf_debounce_bit (sync, counter, dout, rise, fall for one channel) SHALL be instantiated WIDTH times via generate.
REQ-027 Top-level integration: key[0] through this block drives the board reset source; sw[4:0] through it drive reg_addr.

Verification (bench uses WIDTH=4, DB_CYC=4, RST_VAL=0)
REQ-028 Reset held, din=4'hF -> dout=0, rise=0, fall=0; after release and 6 edges, dout=4'hF with rise=4'hF for exactly one cycle.
REQ-029 din[0] 0->1 clean step -> dout[0]=1 on edge 6 after the first sampling edge, rise[0] high for one cycle, fall=0.
REQ-030 din[1] high for 3 cycles then low -> dout[1], rise[1], fall[1] stay 0 throughout.
REQ-031 din[2] bounce 1,0,1,0,1 then steady 1 -> dout[2] rises 6 edges after the last bounce edge, exactly one rise pulse.
REQ-032 Reset asserted with din[3] count at 2 -> dout[3]=0 immediately, no pulse; after release and 6 edges dout[3]=1.
REQ-033 DB_CYC=1 build: din[0] step -> dout[0] changes 3 edges later with a single-cycle rise[0].

Source files
------------

// File: rtl/nf_db_pkg.sv
// Shared constants for the input debouncer.
//   NF_CLK_FREQ : system clock frequency in Hz
//   NF_DB_MS    : debounce window in milliseconds
//   NF_DB_CYC   : debounce window in clock cycles, derived from the two above
package nf_db_pkg;

    localparam int unsigned NF_CLK_FREQ = 50_000_000;
    localparam int unsigned NF_DB_MS    = 10;
    localparam int unsigned NF_DB_CYC   = (NF_CLK_FREQ / 1000) * NF_DB_MS;

endpackage

// File: rtl/nf_input_debounce_if.sv
// Bus carrying raw and debounced channel levels.
//   din  : raw asynchronous levels (driven by the master)
//   dout : debounced, clk-synchronous levels
//   rise : one-cycle pulse per bit on an accepted 0->1 transition
//   fall : one-cycle pulse per bit on an accepted 1->0 transition
interface nf_input_debounce_if #(
    parameter int unsigned WIDTH = 12
);

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output din,
        input  dout,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        output dout,
        output rise,
        output fall
    );

endinterface

// File: rtl/nf_debounce_bit.sv
// Single-channel debouncer: 2-flop synchronizer, stability counter, registered
// level and edge pulses.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   din   : raw asynchronous level
//   dout  : debounced level
//   rise  : one-cycle pulse when dout goes 0->1
//   fall  : one-cycle pulse when dout goes 1->0
module nf_debounce_bit
    import nf_db_pkg::*;
#(
    parameter int unsigned DB_CYC  = NF_DB_CYC,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CntW    = $clog2(DB_CYC + 1);
    localparam logic [CntW-1:0] CntTerm = CntW'(DB_CYC - 1);

    logic            sync1;
    logic            sync2;
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            dout  <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == dout) begin
                // Any return to the accepted level throws away the partial count.
                cnt <= '0;
            end else if (cnt == CntTerm) begin
                dout <= sync2;
                rise <= sync2;
                fall <= ~sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf_input_debounce.sv
// Multi-channel debouncer for board switches and keys. Each channel is
// debounced independently by its own nf_debounce_bit instance.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of nf_input_debounce_if (din in; dout, rise, fall out)
module nf_input_debounce
    import nf_db_pkg::*;
#(
    parameter int unsigned      WIDTH   = 12,
    parameter int unsigned      DB_CYC  = NF_DB_CYC,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    nf_input_debounce_if.slave   bus
);

    logic [WIDTH-1:0] dout_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nf_debounce_bit #(
            .DB_CYC  (DB_CYC),
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .din   (bus.din[i]),
            .dout  (dout_w[i]),
            .rise  (rise_w[i]),
            .fall  (fall_w[i])
        );
    end

    assign bus.dout = dout_w;
    assign bus.rise = rise_w;
    assign bus.fall = fall_w;

endmodule

// File: tb/tb_nf_input_debounce.sv
module tb_nf_input_debounce;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    nf_input_debounce_if #(.WIDTH(4)) b4 ();
    nf_input_debounce_if #(.WIDTH(4)) b1 ();

    nf_input_debounce #(
        .WIDTH   (4),
        .DB_CYC  (4),
        .RST_VAL (4'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.slave)
    );

    nf_input_debounce #(
        .WIDTH   (4),
        .DB_CYC  (1),
        .RST_VAL (4'h0)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise2_cnt;

        // Reset held with all inputs high.
        reset  = 1'b1;
        b4.din = 4'hF;
        b1.din = 4'h0;
        #1;
        chk("rst_dout_async", b4.dout, 4'h0);
        tick();
        tick();
        chk("rst_dout", b4.dout, 4'h0);
        chk("rst_rise", b4.rise, 4'h0);
        chk("rst_fall", b4.fall, 4'h0);

        // Release: all four accepted on the 6th edge.
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("rel_dout", b4.dout, (k >= 6) ? 4'hF : 4'h0);
            chk("rel_rise", b4.rise, (k == 6) ? 4'hF : 4'h0);
            chk("rel_fall", b4.fall, 4'h0);
        end

        // All back to zero: fall pulses.
        b4.din = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("all_fall_dout", b4.dout, (k >= 6) ? 4'h0 : 4'hF);
            chk("all_fall_fall", b4.fall, (k == 6) ? 4'hF : 4'h0);
            chk("all_fall_rise", b4.rise, 4'h0);
        end

        // Clean step on din[0].
        b4.din = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("step0_dout", b4.dout, (k >= 6) ? 4'h1 : 4'h0);
            chk("step0_rise", b4.rise, (k == 6) ? 4'h1 : 4'h0);
            chk("step0_fall", b4.fall, 4'h0);
        end

        // Short pulse on din[1]: rejected.
        b4.din = 4'h3;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) b4.din = 4'h1;
            chk("glitch1_dout", b4.dout, 4'h1);
            chk("glitch1_rise", b4.rise, 4'h0);
            chk("glitch1_fall", b4.fall, 4'h0);
        end

        // Bounce on din[2]: 1,0,1,0 then steady 1.
        rise2_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            b4.din = (k % 2 == 0) ? 4'h5 : 4'h1;
            tick();
            if (b4.rise[2]) rise2_cnt++;
            chk("bounce_dout", b4.dout, 4'h1);
        end
        b4.din = 4'h5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (b4.rise[2]) rise2_cnt++;
            chk("bounce_settle_dout", b4.dout, (k >= 6) ? 4'h5 : 4'h1);
            chk("bounce_settle_rise", b4.rise, (k == 6) ? 4'h4 : 4'h0);
        end
        chk("bounce_rise_count", 4'(rise2_cnt), 4'h1);

        // Reset mid-count on din[3].
        b4.din = 4'hD;
        for (int k = 0; k < 4; k++) tick();
        chk("midcnt_dout_pre", b4.dout, 4'h5);
        reset = 1'b1;
        #1;
        chk("midcnt_rst_dout", b4.dout, 4'h0);
        chk("midcnt_rst_rise", b4.rise, 4'h0);
        chk("midcnt_rst_fall", b4.fall, 4'h0);
        tick();
        tick();
        chk("midcnt_hold_dout", b4.dout, 4'h0);
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("midcnt_rel_dout", b4.dout, (k >= 6) ? 4'hD : 4'h0);
            chk("midcnt_rel_rise", b4.rise, (k == 6) ? 4'hD : 4'h0);
            chk("midcnt_rel_fall", b4.fall, 4'h0);
        end

        // DB_CYC=1 instance: latency 3 each way.
        b1.din = 4'h1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("fast_dout", b1.dout, (k >= 3) ? 4'h1 : 4'h0);
            chk("fast_rise", b1.rise, (k == 3) ? 4'h1 : 4'h0);
            chk("fast_fall", b1.fall, 4'h0);
        end
        b1.din = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("fast_fdout", b1.dout, (k >= 3) ? 4'h0 : 4'h1);
            chk("fast_ffall", b1.fall, (k == 3) ? 4'h1 : 4'h0);
            chk("fast_frise", b1.rise, 4'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
